// File: rtl/count_down_8bit.sv
// 8-bit down-counter with a reloadable start value, one-shot or periodic operation,
// pause, and a one-cycle terminal-count pulse, sequenced by an IDLE/RUN/DONE FSM.
module count_down_8bit #(
  parameter logic [7:0] RLD_INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       auto_reload,
  output logic [7:0] count_out,
  output logic       tc,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] rld;
  logic [7:0] rld_next;
  logic [7:0] count_next;
  logic       tc_next;
  logic       at_zero;

  assign at_zero = (count_out == 8'h00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      count_out <= 8'h00;
      rld       <= RLD_INIT;
      tc        <= 1'b0;
    end else begin
      state     <= state_next;
      count_out <= count_next;
      rld       <= rld_next;
      tc        <= tc_next;
    end
  end

  // LOAD overrides everything else, including a coincident START.
  always_comb begin
    state_next = state;
    count_next = count_out;
    rld_next   = rld;
    tc_next    = 1'b0;
    if (load) begin
      rld_next   = load_val;
      count_next = load_val;
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!pause) begin
            if (!at_zero) begin
              count_next = count_out - 8'd1;
            end else begin
              // AUTO_RELOAD matters only here, at the zero-count edge.
              tc_next = 1'b1;
              if (auto_reload) count_next = rld;
              else             state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            count_next = rld;
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: doc/count_down_8bit.md
COUNT_DOWN_8BIT -- requirements
Module: count_down_8bit

Interface
REQ-001 Parameter RLD_INIT, default 8'hFF: reload register value after reset.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESETN  input  1  reset, asynchronous, active-low.
REQ-004 LOAD  input  1  load strobe; captures LOAD_VAL.
REQ-005 LOAD_VAL  input  8  value for reload register and counter.
REQ-006 START  input  1  start strobe; begins a countdown.
REQ-007 PAUSE  input  1  hold level; freezes countdown while high.
REQ-008 AUTO_RELOAD  input  1  1 = periodic mode, 0 = one-shot mode.
REQ-009 COUNT_OUT  output  8  current counter value, registered.
REQ-010 TC  output  1  terminal-count pulse, registered, one cycle wide.
REQ-011 BUSY  output  1  high while in RUN state.
REQ-012 DONE  output  1  high while in DONE state.

Function
REQ-013 Block SHALL implement a 3-state FSM: IDLE, RUN, DONE; BUSY = (state==RUN), DONE = (state==DONE), decoded from the state register only.
REQ-014 Block SHALL hold an 8-bit reload register RLD, written only by LOAD or reset.
REQ-015 LOAD high at an edge, any state: RLD <= LOAD_VAL, COUNT_OUT <= LOAD_VAL, state -> IDLE, TC <= 0.
REQ-016 LOAD SHALL take priority over START, PAUSE and counting in the same cycle; a coincident START is discarded.
REQ-017 IDLE, START high, LOAD low: state -> RUN; COUNT_OUT unchanged, so the countdown begins from the loaded or held value.
REQ-018 DONE, START high, LOAD low: COUNT_OUT <= RLD, state -> RUN.
REQ-019 START in RUN SHALL be ignored; no restart, no reload.
REQ-020 RUN, PAUSE low, COUNT_OUT != 0: COUNT_OUT <= COUNT_OUT - 1 each edge.
REQ-021 RUN, PAUSE low, COUNT_OUT == 0: TC <= 1 for exactly the next cycle; if AUTO_RELOAD == 1, COUNT_OUT <= RLD and stay in RUN; otherwise COUNT_OUT stays 0 and state -> DONE.
REQ-022 Arithmetic SHALL be unsigned 8-bit; the counter SHALL never wrap from 0 to 8'hFF by decrement.
REQ-023 RUN, PAUSE high: COUNT_OUT and state held, TC <= 0; the countdown resumes from the held value on the first edge with PAUSE low.
REQ-024 PAUSE SHALL have no effect in IDLE or DONE.
REQ-025 TC SHALL be 0 in every cycle not covered by REQ-021.
REQ-026 Countdown from value N, PAUSE low, SHALL produce TC N+1 edges after RUN is entered; in auto-reload mode the TC period SHALL be RLD+1 cycles (RLD=0 gives TC every cycle).
REQ-027 AUTO_RELOAD SHALL be sampled only at the zero-count edge; changing it mid-count SHALL have no other effect.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next edge with outputs per REQ-015 rules (TC=0).

Reset
REQ-029 RESETN low SHALL immediately, without a clock: state = IDLE, COUNT_OUT = 8'h00, RLD = RLD_INIT, TC = 0, BUSY = 0, DONE = 0.
REQ-030 Reset asserted mid-countdown SHALL abort it; after release, START first runs from COUNT_OUT = 0 (TC on the next edge), then DONE.
REQ-031 The first rising edge after RESETN rises SHALL be a normal functional edge.

Verification
REQ-032 Reset/one-shot: RESETN low 100 ns, clock 50 ns period; LOAD 8'h05, START, AUTO_RELOAD=0 -> COUNT_OUT 5,4,3,2,1,0, TC high the 6th cycle after START, DONE high, BUSY low, COUNT_OUT holds 0.
REQ-033 Auto-reload: LOAD 8'h03, AUTO_RELOAD=1, START -> TC every 4 cycles for 5 periods; COUNT_OUT sequence 3,2,1,0,3,...; BUSY stays 1.
REQ-034 Pause: LOAD 8'h0A, START, PAUSE high 7 cycles at COUNT_OUT=6 -> COUNT_OUT holds 6, TC low; TC fires 7 cycles after PAUSE falls.
REQ-035 Priority: LOAD 8'h20 and START in the same cycle while RUN -> COUNT_OUT=8'h20, state IDLE, BUSY low; a later START counts from 8'h20.
REQ-036 Boundary: LOAD 8'h00, AUTO_RELOAD=1, START -> TC high every cycle; LOAD 8'hFF one-shot -> TC after 256 cycles, no wrap to 8'hFF.
REQ-037 Async reset: assert RESETN low between clock edges at COUNT_OUT=8'h40 -> all outputs reach reset values before the next edge; DONE restart uses RLD = 8'hFF.
